// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and constants for the multimeter sampling path
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        CONVERT   = 2'd2,
        DRAIN     = 2'd3
    } adc_ctrl_state_t;

    localparam int FLG_DROP    = 0;
    localparam int FLG_MISS    = 1;
    localparam int FLG_TIMEOUT = 2;
    localparam int FLG_W       = 3;

endpackage

// File: rtl/mm_tick_gen.sv
// rtl/mm_tick_gen.sv - periodic one-cycle tick from a reloading down-counter
module mm_tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LOAD = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;

    // Count down while enabled; reload at zero and whenever disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= LOAD;
        end else if (!en_i || (r_cnt == '0)) begin
            r_cnt <= LOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Not gated by en_i: the counter can only be zero after an enabled cycle,
    // and leaving en_i out keeps callers free to derive en_i from tick_o.
    assign tick_o = (r_cnt == '0);

endmodule

// File: rtl/adc_sample_ctrl.sv
// rtl/adc_sample_ctrl.sv - periodic SPI ADC conversion scheduler with single-entry output register
module adc_sample_ctrl
    import mm_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SAMPLE_HZ   = 10_000,
    parameter int TIMEOUT_CYC = 4096,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic              ch_sel_i,
    input  logic              clr_i,
    output logic              adc_en_o,
    input  logic              adc_update_i,
    input  logic [DATA_W-1:0] adc_data0_i,
    input  logic [DATA_W-1:0] adc_data1_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              busy_o,
    output logic [FLG_W-1:0]  flags_o,
    output logic [15:0]       sample_cnt_o
);

    localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    adc_ctrl_state_t    r_state;
    adc_ctrl_state_t    w_state_nxt;
    logic               w_tick;
    logic               w_tick_en;
    logic               w_start;
    logic               w_update;
    logic               w_timeout;
    logic               w_miss;
    logic               w_load;
    logic               w_drop;
    logic [FLG_W-1:0]   w_flag_set;
    logic [TW-1:0]      r_tmo_cnt;
    logic               r_ch_sel;
    logic               r_adc_en;
    logic               r_busy;
    logic [DATA_W-1:0]  r_sample;
    logic               r_valid;
    logic [FLG_W-1:0]   r_flags;
    logic [15:0]        r_sample_cnt;

    // The tick counter runs in every state except IDLE, so leaving IDLE
    // starts a fresh PERIOD and dropping back to IDLE reloads it.
    assign w_tick_en = (w_state_nxt != IDLE);

    mm_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (w_tick_en),
        .tick_o (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle events; a completed update beats a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_update    = 1'b0;
        w_timeout   = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            IDLE: begin
                if (run_i) begin
                    w_state_nxt = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!run_i) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_start     = 1'b1;
                    w_state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                w_miss = w_tick;
                if (adc_update_i) begin
                    w_update    = 1'b1;
                    w_state_nxt = run_i ? WAIT_TICK : IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = run_i ? WAIT_TICK : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A finished conversion is loaded if the register is free or being emptied this cycle.
    assign w_load = w_update && (!r_valid || sample_ready_i);
    assign w_drop = w_update && !w_load;

    // Gather the flag events into their bit positions.
    always_comb begin
        w_flag_set              = '0;
        w_flag_set[FLG_DROP]    = w_drop;
        w_flag_set[FLG_MISS]    = w_miss;
        w_flag_set[FLG_TIMEOUT] = w_timeout;
    end

    // Conversion start pulse, channel latch, timeout counter and busy indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_en  <= 1'b0;
            r_ch_sel  <= 1'b0;
            r_tmo_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_adc_en <= w_start;
            r_busy   <= (w_state_nxt == CONVERT);
            if (w_start) begin
                r_ch_sel  <= ch_sel_i;
                r_tmo_cnt <= '0;
            end else if (r_state == CONVERT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    // Single-entry output register with valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else if (w_load) begin
            r_sample <= r_ch_sel ? adc_data1_i : adc_data0_i;
            r_valid  <= 1'b1;
        end else if (r_valid && sample_ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    // Sticky flags and load counter; a same-cycle event wins over clr_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags      <= '0;
            r_sample_cnt <= '0;
        end else if (clr_i) begin
            r_flags      <= w_flag_set;
            r_sample_cnt <= w_load ? 16'd1 : 16'd0;
        end else begin
            r_flags      <= r_flags | w_flag_set;
            r_sample_cnt <= r_sample_cnt + {15'd0, w_load};
        end
    end

    assign adc_en_o       = r_adc_en;
    assign busy_o         = r_busy;
    assign sample_o       = r_sample;
    assign sample_valid_o = r_valid;
    assign flags_o        = r_flags;
    assign sample_cnt_o   = r_sample_cnt;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb/tb_adc_sample_ctrl.sv - self-checking bench for adc_sample_ctrl
module tb_adc_sample_ctrl;

    localparam int PERIOD      = 10;
    localparam int TIMEOUT_CYC = 16;
    localparam int RESP_DLY    = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_i;
    logic        ch_sel_i;
    logic        clr_i;
    logic        adc_en_o;
    logic        adc_update_i;
    logic [11:0] adc_data0_i;
    logic [11:0] adc_data1_i;
    logic [11:0] sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        busy_o;
    logic [2:0]  flags_o;
    logic [15:0] sample_cnt_o;

    int errors = 0;
    int checks = 0;

    adc_sample_ctrl #(
        .CLK_HZ      (1000),
        .SAMPLE_HZ   (100),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .DATA_W      (12)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_i          (run_i),
        .ch_sel_i       (ch_sel_i),
        .clr_i          (clr_i),
        .adc_en_o       (adc_en_o),
        .adc_update_i   (adc_update_i),
        .adc_data0_i    (adc_data0_i),
        .adc_data1_i    (adc_data1_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .busy_o         (busy_o),
        .flags_o        (flags_o),
        .sample_cnt_o   (sample_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ADC responder ----------------
    bit resp_en;
    int resp_cd;

    initial begin
        adc_update_i = 1'b0;
        resp_cd      = 0;
        forever begin
            @(negedge clk);
            adc_update_i = 1'b0;
            if (resp_cd > 0) begin
                resp_cd--;
                if (resp_cd == 0) adc_update_i = 1'b1;
            end
            if (adc_en_o && resp_en) resp_cd = RESP_DLY;
        end
    end

    // ---------------- behavioural model (time-slot based) ----------------
    // m_active: sampling enabled; m_conv: a conversion is outstanding.
    // m_slot is the absolute cycle at which the next start pulse may appear.
    bit          m_ok;
    bit          m_active;
    bit          m_conv;
    longint      m_cyc;
    longint      m_slot;
    longint      m_start;
    bit          m_ch;
    bit          e_en;
    bit          e_busy;
    logic [11:0] m_data;
    bit          m_valid;
    logic [15:0] m_cnt;
    logic [2:0]  m_flags;

    task automatic model_reset();
        m_active = 0;
        m_conv   = 0;
        m_ch     = 0;
        e_en     = 0;
        e_busy   = 0;
        m_data   = '0;
        m_valid  = 0;
        m_cnt    = '0;
        m_flags  = '0;
        m_ok     = 1;
    endtask

    task automatic model_step();
        bit got;
        bit load;
        bit drop;
        bit miss;
        bit tmo;
        got  = 0;
        load = 0;
        drop = 0;
        miss = 0;
        tmo  = 0;
        e_en = 0;
        if (!m_active) begin
            if (run_i) begin
                m_active = 1;
                m_slot   = m_cyc + PERIOD;
            end
        end else if (!m_conv) begin
            if (!run_i) begin
                m_active = 0;
            end else if (m_cyc + 1 == m_slot) begin
                e_en    = 1;
                m_conv  = 1;
                m_start = m_cyc + 1;
                m_ch    = ch_sel_i;
                m_slot  = m_slot + PERIOD;
            end
        end else begin
            if (m_cyc + 1 == m_slot) begin
                miss   = 1;
                m_slot = m_slot + PERIOD;
            end
            if (adc_update_i) begin
                got = 1;
            end else if (m_cyc + 1 - m_start == TIMEOUT_CYC) begin
                tmo = 1;
            end
            if (got || tmo) begin
                m_conv   = 0;
                m_active = run_i;
            end
        end
        if (got) begin
            if (!m_valid || sample_ready_i) load = 1;
            else drop = 1;
        end
        if (load) begin
            m_data  = m_ch ? adc_data1_i : adc_data0_i;
            m_valid = 1;
        end else if (m_valid && sample_ready_i) begin
            m_valid = 0;
        end
        if (clr_i) begin
            m_cnt   = load ? 16'd1 : 16'd0;
            m_flags = {tmo, miss, drop};
        end else begin
            m_cnt   = m_cnt + (load ? 16'd1 : 16'd0);
            m_flags = m_flags | {tmo, miss, drop};
        end
        e_busy = m_conv;
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            m_cyc++;
        end
    end

    // Compare DUT against the model every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && m_ok) begin
                chk("cyc_adc_en", {31'd0, adc_en_o}, {31'd0, e_en});
                chk("cyc_busy", {31'd0, busy_o}, {31'd0, e_busy});
                chk("cyc_valid", {31'd0, sample_valid_o}, {31'd0, m_valid});
                chk("cyc_sample", {20'd0, sample_o}, {20'd0, m_data});
                chk("cyc_flags", {29'd0, flags_o}, {29'd0, m_flags});
                chk("cyc_cnt", {16'd0, sample_cnt_o}, {16'd0, m_cnt});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_en(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_en_o && n < 60);
        if (!adc_en_o) begin
            checks++;
            errors++;
            $display("FAIL wait_en: no adc_en_o within %0d cycles", n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_adc_en"}, {31'd0, adc_en_o}, 32'd0);
        chk({tag, "_sample"}, {20'd0, sample_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, sample_valid_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_flags"}, {29'd0, flags_o}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, sample_cnt_o}, 32'd0);
    endtask

    initial begin
        int n;
        int k;
        rst_n          = 1'b0;
        run_i          = 1'b0;
        ch_sel_i       = 1'b0;
        clr_i          = 1'b0;
        sample_ready_i = 1'b1;
        resp_en        = 1;
        adc_data0_i    = 12'hABC;
        adc_data1_i    = 12'h123;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Steady run, channel 0
        run_i = 1'b1;
        wait_en(n);
        chk("first_en_latency", n, 32'd10);
        @(negedge clk);
        chk("busy_in_convert", {31'd0, busy_o}, 32'd1);
        repeat (5) @(negedge clk);
        chk("first_sample", {20'd0, sample_o}, 32'hABC);
        chk("first_valid", {31'd0, sample_valid_o}, 32'd1);
        chk("first_cnt", {16'd0, sample_cnt_o}, 32'd1);
        chk("busy_after_update", {31'd0, busy_o}, 32'd0);
        wait_en(n);
        chk("en_spacing", n, 32'd4);
        repeat (6) @(negedge clk);
        chk("second_cnt", {16'd0, sample_cnt_o}, 32'd2);
        chk("steady_flags", {29'd0, flags_o}, 32'd0);

        // Backpressure for three periods
        @(negedge clk);
        clr_i          = 1'b1;
        sample_ready_i = 1'b0;
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr_cnt_zero", {16'd0, sample_cnt_o}, 32'd0);
        wait_en(n);
        repeat (6) @(negedge clk);
        chk("held_valid", {31'd0, sample_valid_o}, 32'd1);
        adc_data0_i = 12'h555;
        wait_en(n);
        wait_en(n);
        repeat (6) @(negedge clk);
        chk("drop_flags", {29'd0, flags_o}, 32'd1);
        chk("drop_cnt", {16'd0, sample_cnt_o}, 32'd1);
        chk("drop_held_sample", {20'd0, sample_o}, 32'hABC);
        sample_ready_i = 1'b1;
        @(negedge clk);
        chk("valid_clears", {31'd0, sample_valid_o}, 32'd0);

        // clr in the same cycle as a drop
        clr_i          = 1'b1;
        sample_ready_i = 1'b0;
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr_flags", {29'd0, flags_o}, 32'd0);
        wait_en(n);
        wait_en(n);
        repeat (5) @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr_vs_drop_flags", {29'd0, flags_o}, 32'd1);
        chk("clr_vs_drop_cnt", {16'd0, sample_cnt_o}, 32'd0);
        sample_ready_i = 1'b1;
        clr_i          = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;

        // Counter wrap
        wait_en(n);
        @(negedge clk);
        #1;
        force u_dut.r_sample_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release u_dut.r_sample_cnt;
        repeat (5) @(negedge clk);
        chk("cnt_wrap", {16'd0, sample_cnt_o}, 32'd0);
        chk("wrap_sample", {20'd0, sample_o}, 32'h555);

        // ADC never answers
        resp_en = 0;
        wait_en(n);
        repeat (15) @(negedge clk);
        chk("tmo_busy_before", {31'd0, busy_o}, 32'd1);
        chk("tmo_flags_before", {29'd0, flags_o}, 32'd2);
        @(negedge clk);
        chk("tmo_busy_after", {31'd0, busy_o}, 32'd0);
        chk("tmo_flags", {29'd0, flags_o}, 32'd6);
        chk("tmo_no_load", {31'd0, sample_valid_o}, 32'd0);
        resp_en = 1;
        wait_en(n);
        chk("en_after_tmo", n, 32'd4);

        // run_i dropped mid-conversion
        repeat (2) @(negedge clk);
        run_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("rundrop_valid", {31'd0, sample_valid_o}, 32'd1);
        chk("rundrop_cnt", {16'd0, sample_cnt_o}, 32'd1);
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (adc_en_o) k++;
        end
        chk("rundrop_no_en", k, 32'd0);
        run_i    = 1'b1;
        ch_sel_i = 1'b1;
        wait_en(n);
        chk("restart_latency", n, 32'd10);

        // Reset during CONVERT
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("late_update_valid", {31'd0, sample_valid_o}, 32'd0);
        chk("late_update_cnt", {16'd0, sample_cnt_o}, 32'd0);
        wait_en(n);
        chk("post_rst_latency", n, 32'd6);
        repeat (6) @(negedge clk);
        chk("ch1_sample", {20'd0, sample_o}, 32'h123);

        run_i = 1'b0;
        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Conversion scheduler for the multimeter's SPI ADC front end. It starts one `spi_adc` conversion per sample period and waits for the result. It then forwards the selected 12-bit channel to the downstream filter/display chain over a valid/ready handshake. It also reports missed ticks, dropped samples and ADC timeouts as sticky flags. It sits between `spi_adc` (driving its `en_i`) and the FIR/IIR/RMS consumers.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SAMPLE_HZ`, 10_000, conversion start rate. `PERIOD = CLK_HZ/SAMPLE_HZ` must be ≥ 2.
- `TIMEOUT_CYC`, 4096, maximum cycles from start pulse to `adc_update_i`.
- `DATA_W`, 12, ADC sample width.

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, reset: asynchronous, active-low.
- `run_i`, in, 1, level; enables periodic sampling.
- `ch_sel_i`, in, 1, channel to forward: 0 = data0, 1 = data1. Sampled at each start pulse.
- `clr_i`, in, 1, single-cycle pulse; clears `flags_o` and `sample_cnt_o`.
- `adc_en_o`, out, 1, single-cycle conversion start to `spi_adc`.
- `adc_update_i`, in, 1, single-cycle conversion-done pulse from `spi_adc`.
- `adc_data0_i`, in, DATA_W, ADC channel 0 result. Valid when `adc_update_i` is high.
- `adc_data1_i`, in, DATA_W, ADC channel 1 result. Valid when `adc_update_i` is high.
- `sample_o`, out, DATA_W, forwarded sample.
- `sample_valid_o`, out, 1, `sample_o` is valid.
- `sample_ready_i`, in, 1, downstream accepts the sample.
- `busy_o`, out, 1, high while in state CONVERT.
- `flags_o`, out, 3, sticky flags:
  - [0] DROP: a sample was discarded because the output register was full.
  - [1] MISS: a tick arrived during CONVERT.
  - [2] TIMEOUT: `adc_update_i` did not arrive within `TIMEOUT_CYC`.
- `sample_cnt_o`, out, 16, count of samples loaded into the output register. Wraps at 0xFFFF→0.

## Operation
- Tick generator: down-counter loaded with `PERIOD-1`.
  - Emits a one-cycle `tick` when it reaches 0, then reloads.
  - Held at `PERIOD-1` while in state IDLE.
- FSM states: IDLE, WAIT_TICK, CONVERT, DRAIN.
  - IDLE: when `run_i`=1, go to WAIT_TICK.
  - WAIT_TICK:
    - If `run_i`=0, go to IDLE.
    - On `tick`: assert `adc_en_o`, latch `ch_sel_i`, clear the timeout counter, go to CONVERT.
  - CONVERT:
    - On `adc_update_i`: load the sample, then go to WAIT_TICK if `run_i`=1, else IDLE.
    - If the timeout counter reaches `TIMEOUT_CYC-1` first: set TIMEOUT, discard any later update, leave CONVERT by the same `run_i` rule.
    - A `tick` in this state sets MISS and does not start a conversion.
    - Deasserting `run_i` does not abort the conversion in progress.
  - DRAIN: reserved encoding, unreachable. Any illegal state recovers to IDLE.
- Output register (single entry, valid/ready):
  - A load happens when `sample_valid_o`=0, or when `sample_ready_i`=1 in the same cycle. A load sets `sample_valid_o` and increments `sample_cnt_o`.
  - Otherwise the new sample is discarded and DROP is set. The held sample is kept unchanged.
  - `sample_valid_o` clears on `sample_valid_o & sample_ready_i` when no load occurs in that cycle.
  - `sample_o` is stable while `sample_valid_o`=1 and `sample_ready_i`=0.
- `clr_i` against a same-cycle flag set: the set wins. The counter goes to 0, or to 1 if a load occurs in the same cycle.
- `adc_update_i` outside CONVERT is ignored and sets no flag.

## Timing
- Reset values:
  - State: IDLE.
  - `adc_en_o`=0, `sample_o`=0, `sample_valid_o`=0, `busy_o`=0, `flags_o`=0, `sample_cnt_o`=0.
  - Tick counter: `PERIOD-1`.
- First `adc_en_o` comes `PERIOD` cycles after the first cycle with `run_i`=1 in IDLE. Subsequent pulses are exactly `PERIOD` cycles apart.
- `adc_update_i` high in cycle N → `sample_o`/`sample_valid_o` updated at cycle N+1, and the FSM leaves CONVERT at N+1.
- Timeout: with no update, TIMEOUT is set and CONVERT is left `TIMEOUT_CYC` cycles after the `adc_en_o` cycle.
- All outputs are registered. There is no combinational path from input to output.
- Reset mid-conversion: immediate return to the reset values. A late `adc_update_i` is then ignored because the FSM is not in CONVERT.

## Structure
- `mm_pkg` holds:
  - `adc_ctrl_state_t` enum {IDLE, WAIT_TICK, CONVERT, DRAIN}.
  - Flag index constants `FLG_DROP`=0, `FLG_MISS`=1, `FLG_TIMEOUT`=2.
- Sub-module `mm_tick_gen` (parameter `PERIOD`; ports `clk`, `rst_n`, `en_i`, `tick_o`). It is reused by the display-refresh and UART pacing logic.
- The FSM, timeout counter, output register and flags live in `adc_sample_ctrl`.

## Test plan
All scenarios use `CLK_HZ`=1000, `SAMPLE_HZ`=100 (`PERIOD`=10), `TIMEOUT_CYC`=16, and an ADC model that responds 5 cycles after start.
- Steady run, `sample_ready_i`=1, `ch_sel_i`=0, data0=0xABC: `adc_en_o` every 10 cycles; `sample_o`=0xABC; `sample_cnt_o` advances by 1 per period; `flags_o`=0.
- `sample_ready_i`=0 for 3 periods: first sample held, 2 drops, `flags_o`=3'b001, `sample_cnt_o`=1. Then ready=1: valid clears one cycle later.
- ADC model never responds: TIMEOUT is set 16 cycles after `adc_en_o`. That exceeds `PERIOD`, so a tick falls inside CONVERT and MISS is also set (`flags_o`=3'b110). No sample is loaded.
- `run_i` dropped 2 cycles after `adc_en_o`: the conversion completes and the sample is delivered, then IDLE. No further `adc_en_o`; the tick counter reads 9.
- `clr_i` pulse in the same cycle as a DROP event: `flags_o`=3'b001 afterwards. `sample_cnt_o` goes from 0xFFFF to 0 on a load without clr.
- `rst_n` asserted during CONVERT: all outputs go to reset values asynchronously. An `adc_update_i` pulse after release produces no sample.
